// File: rtl/uart_pkg.sv
// Shared constants and state encoding for the UART transmit path.
package uart_pkg;

    localparam int unsigned FRAME_W = 10;

    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

    // Line-idle pattern presented while no frame has been loaded.
    localparam logic [FRAME_W-1:0] IDLE_FRAME = 10'h3FF;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StStrobe = 2'd1,
        StHold   = 2'd2
    } feeder_state_e;

endpackage

// File: rtl/uart_byte_fifo.sv
// Byte FIFO with registered FULL/EMPTY and a sticky overflow flag; synchronous active-high reset.
module uart_byte_fifo #(
    parameter int unsigned DEPTH = 8
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       WR,
    input  logic [7:0] DIN,
    input  logic       RD,
    output logic [7:0] DOUT,
    output logic       FULL,
    output logic       EMPTY,
    output logic       OVF
);

    localparam int unsigned AW = $clog2(DEPTH);

    typedef logic [AW:0] ptr_t;

    ptr_t       wptr_q, wptr_d;
    ptr_t       rptr_q, rptr_d;
    logic       full_q;
    logic       empty_q;
    logic       ovf_q;
    logic [7:0] mem_q [DEPTH];
    logic       do_write;
    logic       do_read;

    // A write into a full FIFO is dropped even when a pop frees a slot in the same cycle.
    assign do_write = WR && !full_q;
    assign do_read  = RD && !empty_q;

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (do_write) begin
            wptr_d = wptr_q + ptr_t'(1);
        end
        if (do_read) begin
            rptr_d = rptr_q + ptr_t'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
            ovf_q   <= 1'b0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            // Pointer MSBs differ only when the writer has lapped the reader.
            full_q  <= (wptr_d[AW] != rptr_d[AW]) && (wptr_d[AW-1:0] == rptr_d[AW-1:0]);
            empty_q <= (wptr_d == rptr_d);
            if (WR && full_q) begin
                ovf_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (do_write) begin
            mem_q[wptr_q[AW-1:0]] <= DIN;
        end
    end

    assign DOUT  = mem_q[rptr_q[AW-1:0]];
    assign FULL  = full_q;
    assign EMPTY = empty_q;
    assign OVF   = ovf_q;

endmodule

// File: rtl/uart_tx_feeder.sv
// Buffers host bytes and hands framed words to the UART transmitter, one EN pulse per frame.
// Define UART_TX_FEEDER_PARITY_EN for 7E1 framing; default build is 8N1.
module uart_tx_feeder
    import uart_pkg::*;
#(
    parameter int unsigned DEPTH     = 8,
    parameter int unsigned FRAME_GAP = 12
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic [7:0]         DIN,
    input  logic               WR,
    output logic               FULL,
    output logic               EMPTY,
    output logic               OVF,
    output logic [FRAME_W-1:0] DATASD,
    output logic               EN,
    output logic               BUSY
);

    // The transmitter needs 13 cycles after EN to get back to WAIT.
    if (FRAME_GAP < 11) begin : g_bad_gap
        $error("uart_tx_feeder: FRAME_GAP must be at least 11");
    end
    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("uart_tx_feeder: DEPTH must be a power of 2 and at least 2");
    end

    localparam int unsigned GW = $clog2(FRAME_GAP);
    localparam logic [GW-1:0] GapLast = GW'(FRAME_GAP - 1);

    feeder_state_e      state_q;
    logic [GW-1:0]      gap_q;
    logic [FRAME_W-1:0] datasd_q;
    logic [7:0]         head;
    logic               fifo_empty;
    logic               pop;

    function automatic logic [FRAME_W-1:0] build_frame(input logic [7:0] b);
`ifdef UART_TX_FEEDER_PARITY_EN
        return {STOP_BIT, ^b[6:0], b[6:0], START_BIT};
`else
        return {STOP_BIT, b, START_BIT};
`endif
    endfunction

    assign pop = (state_q == StIdle) && !fifo_empty;

    uart_byte_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .CLK   (CLK),
        .RST   (RST),
        .WR    (WR),
        .DIN   (DIN),
        .RD    (pop),
        .DOUT  (head),
        .FULL  (FULL),
        .EMPTY (fifo_empty),
        .OVF   (OVF)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= StIdle;
            gap_q    <= '0;
            datasd_q <= IDLE_FRAME;
        end else begin
            case (state_q)
                StIdle: begin
                    if (!fifo_empty) begin
                        datasd_q <= build_frame(head);
                        state_q  <= StStrobe;
                    end
                end
                StStrobe: begin
                    gap_q   <= '0;
                    state_q <= StHold;
                end
                StHold: begin
                    if (gap_q == GapLast) begin
                        state_q <= StIdle;
                    end else begin
                        gap_q <= gap_q + GW'(1);
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    // DATASD only changes on a pop, so it stays valid through the transmitter's latch cycle.
    assign DATASD = datasd_q;
    assign EN     = (state_q == StStrobe);
    assign EMPTY  = fifo_empty;
    assign BUSY   = (state_q != StIdle) || !fifo_empty;

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Directed bench for uart_tx_feeder: frame table plus burst, overflow and mid-frame reset sequences.
module tb_uart_tx_feeder;

    localparam int unsigned DEPTH     = 8;
    localparam int unsigned FRAME_GAP = 12;
    localparam int          SPACING   = FRAME_GAP + 2;
    localparam int          NVEC      = 7;

    logic       CLK = 1'b0;
    logic       RST;
    logic [7:0] DIN;
    logic       WR;
    logic       FULL;
    logic       EMPTY;
    logic       OVF;
    logic [9:0] DATASD;
    logic       EN;
    logic       BUSY;

    int n_vec = 0;
    int n_err = 0;

    always #5 CLK = ~CLK;

    uart_tx_feeder #(
        .DEPTH     (DEPTH),
        .FRAME_GAP (FRAME_GAP)
    ) dut (
        .CLK    (CLK),
        .RST    (RST),
        .DIN    (DIN),
        .WR     (WR),
        .FULL   (FULL),
        .EMPTY  (EMPTY),
        .OVF    (OVF),
        .DATASD (DATASD),
        .EN     (EN),
        .BUSY   (BUSY)
    );

    typedef struct {
        logic [7:0] din;
        logic [9:0] frame;
    } vec_t;

    vec_t vecs [NVEC];

    function automatic logic [9:0] frame_of(input logic [7:0] b);
`ifdef UART_TX_FEEDER_PARITY_EN
        return {1'b1, ^b[6:0], b[6:0], 1'b0};
`else
        return {1'b1, b, 1'b0};
`endif
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Advance one edge and sample 1 ns after it.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic       en_seen;
        logic       hold_ok;
        logic [9:0] tx_seq;
        int         pulse_t [16];
        logic [9:0] pulse_f [16];
        int         npulse;

`ifdef UART_TX_FEEDER_PARITY_EN
        vecs[0] = '{8'hA5, 10'h34A};
        vecs[1] = '{8'h00, 10'h200};
        vecs[2] = '{8'hFF, 10'h3FE};
        vecs[3] = '{8'h3C, 10'h278};
        vecs[4] = '{8'h81, 10'h302};
        vecs[5] = '{8'h07, 10'h30E};
        vecs[6] = '{8'h80, 10'h200};
`else
        vecs[0] = '{8'hA5, 10'h34A};
        vecs[1] = '{8'h00, 10'h200};
        vecs[2] = '{8'hFF, 10'h3FE};
        vecs[3] = '{8'h3C, 10'h278};
        vecs[4] = '{8'h81, 10'h302};
        vecs[5] = '{8'h07, 10'h20E};
        vecs[6] = '{8'h80, 10'h300};
`endif

        RST = 1'b1;
        WR  = 1'b0;
        DIN = 8'h00;
        tick();
        tick();
        RST = 1'b0;

        // Reset state, then 20 idle cycles.
        en_seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            en_seen |= EN;
        end
        check("idle datasd", DATASD, 10'h3FF);
        check("idle en", en_seen, 0);
        check("idle empty", EMPTY, 1);
        check("idle busy", BUSY, 0);
        check("idle full", FULL, 0);
        check("idle ovf", OVF, 0);

        // Single-byte frames from the table.
        for (int i = 0; i < NVEC; i++) begin
            DIN = vecs[i].din;
            WR  = 1'b1;
            tick();
            WR = 1'b0;
            check($sformatf("v%0d empty after wr", i), EMPTY, 0);
            check($sformatf("v%0d en early", i), EN, 0);
            tick();
            check($sformatf("v%0d en", i), EN, 1);
            check($sformatf("v%0d datasd", i), DATASD, vecs[i].frame);
            tx_seq    = '0;
            tx_seq[0] = DATASD[0];
            hold_ok   = 1'b1;
            en_seen   = 1'b0;
            for (int c = 1; c < SPACING; c++) begin
                tick();
                en_seen |= EN;
                if (DATASD !== vecs[i].frame) hold_ok = 1'b0;
                if (c < 10) tx_seq[c] = DATASD[c];
            end
            check($sformatf("v%0d hold stable", i), hold_ok, 1);
            check($sformatf("v%0d extra en", i), en_seen, 0);
            check($sformatf("v%0d tx bits", i), tx_seq, vecs[i].frame);
            check($sformatf("v%0d busy after gap", i), BUSY, 0);
        end

        // Lead frame, then fill the FIFO during its HOLD window.
        DIN = 8'h55;
        WR  = 1'b1;
        tick();
        WR = 1'b0;
        tick();
        check("lead en", EN, 1);
        for (int i = 0; i < 8; i++) begin
            DIN = 8'(i);
            WR  = 1'b1;
            tick();
        end
        check("burst full", FULL, 1);
        check("burst ovf before", OVF, 0);
        DIN = 8'h99;
        tick();
        WR = 1'b0;
        check("ovf set", OVF, 1);
        check("full after drop", FULL, 1);

        npulse = 0;
        for (int t = 10; t < 9 * SPACING + 30; t++) begin
            tick();
            if (EN === 1'b1) begin
                if (npulse < 16) begin
                    pulse_t[npulse] = t;
                    pulse_f[npulse] = DATASD;
                end
                npulse++;
            end
        end
        check("burst pulse count", npulse, 8);
        for (int k = 0; k < 8 && k < npulse; k++) begin
            check($sformatf("burst en time %0d", k), pulse_t[k], SPACING * (k + 1));
            check($sformatf("burst frame %0d", k), pulse_f[k], frame_of(8'(k)));
        end
        check("ovf sticky", OVF, 1);
        check("burst drained", EMPTY, 1);

        // Reset during HOLD with three bytes queued.
        DIN = 8'hA5;
        WR  = 1'b1;
        tick();
        WR = 1'b0;
        tick();
        check("rst lead en", EN, 1);
        for (int i = 0; i < 3; i++) begin
            DIN = 8'h10 + 8'(i);
            WR  = 1'b1;
            tick();
        end
        WR = 1'b0;
        tick();
        check("rst queued", EMPTY, 0);
        RST = 1'b1;
        tick();
        RST = 1'b0;
        check("rst datasd", DATASD, 10'h3FF);
        check("rst empty", EMPTY, 1);
        check("rst en", EN, 0);
        check("rst ovf", OVF, 0);
        check("rst busy", BUSY, 0);
        check("rst full", FULL, 0);
        en_seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            tick();
            en_seen |= EN;
        end
        check("rst no en", en_seen, 0);
        check("rst datasd held", DATASD, 10'h3FF);

        // Reset landing on the STROBE cycle must drop EN.
        DIN = 8'h3C;
        WR  = 1'b1;
        tick();
        WR = 1'b0;
        tick();
        check("strobe rst en before", EN, 1);
        RST = 1'b1;
        tick();
        RST = 1'b0;
        check("strobe rst en after", EN, 0);
        check("strobe rst datasd", DATASD, 10'h3FF);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
